// File: rtl/danger_pkg.sv
// danger_pkg: obstacle type codes, sprite geometry and ROM ids for the danger sprite engine.
package danger_pkg;
    typedef enum logic [2:0] {
        LOW_BIRD  = 3'd0,
        HIGH_BIRD = 3'd1,
        SMALL     = 3'd2,
        MANY      = 3'd3,
        BIG       = 3'd4,
        NOTHING   = 3'd5
    } danger_t;

    localparam logic [1:0] ID_SMALL = 2'd0;
    localparam logic [1:0] ID_BIG   = 2'd1;
    localparam logic [1:0] ID_MANY  = 2'd2;
    localparam logic [1:0] ID_BIRD  = 2'd3;

    localparam int SMALL_W = 19, SMALL_H = 36, SMALL_B = 298;
    localparam int BIG_W   = 27, BIG_H   = 50, BIG_B   = 298;
    localparam int MANY_W  = 77, MANY_H  = 49, MANY_B  = 298;
    localparam int BIRD_W  = 47, BIRD_H  = 42;
    localparam int LOW_B   = 290, HIGH_B = 250;
    localparam int BIRD_FRAME_WORDS = 1974;

    typedef struct packed {
        logic       ok;
        logic [6:0] w;
        logic [5:0] h;
        logic [8:0] b;
        logic [1:0] id;
    } geom_t;

    function automatic geom_t geom(input logic [2:0] t);
        case (t)
            SMALL:     return {1'b1, 7'(SMALL_W), 6'(SMALL_H), 9'(SMALL_B), ID_SMALL};
            BIG:       return {1'b1, 7'(BIG_W), 6'(BIG_H), 9'(BIG_B), ID_BIG};
            MANY:      return {1'b1, 7'(MANY_W), 6'(MANY_H), 9'(MANY_B), ID_MANY};
            LOW_BIRD:  return {1'b1, 7'(BIRD_W), 6'(BIRD_H), 9'(LOW_B), ID_BIRD};
            HIGH_BIRD: return {1'b1, 7'(BIRD_W), 6'(BIRD_H), 9'(HIGH_B), ID_BIRD};
            default:   return '0;
        endcase
    endfunction
endpackage

// File: rtl/danger_sprite_engine_if.sv
// danger_sprite_engine_if: obstacle state, raster position, sprite ROM port and pixel output.
interface danger_sprite_engine_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 12
);
    logic [NUM_CH*10-1:0]     danger_pos;
    logic [NUM_CH*3-1:0]      danger_type;
    logic [NUM_CH-1:0]        danger_en;
    logic                     anim_run;
    logic [9:0]               h_cnt;
    logic [9:0]               v_cnt;
    logic [NUM_CH*ADDR_W-1:0] rom_addr;
    logic [NUM_CH*2-1:0]      rom_id;
    logic [NUM_CH*12-1:0]     rom_data;
    logic [11:0]              rgb;
    logic                     overlap;

    modport master (
        output danger_pos, danger_type, danger_en, anim_run, h_cnt, v_cnt, rom_data,
        input  rom_addr, rom_id, rgb, overlap
    );
    modport slave (
        input  danger_pos, danger_type, danger_en, anim_run, h_cnt, v_cnt, rom_data,
        output rom_addr, rom_id, rgb, overlap
    );
endinterface

// File: rtl/danger_ch_addr.sv
// danger_ch_addr: hit test and sprite ROM address for one latched obstacle channel.
module danger_ch_addr
    import danger_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [2:0]        i_type,
    input  logic [9:0]        i_pos,
    input  logic [9:0]        i_h,
    input  logic [9:0]        i_v,
    input  logic              i_phase,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_id
);
    geom_t              w_g;
    logic signed [10:0] w_x0;
    logic signed [10:0] w_col;
    logic signed [10:0] w_row;
    logic               w_hit;
    logic [ADDR_W-1:0]  w_addr;

    assign w_g   = geom(i_type);
    // Unclamped left edge may go negative; col keeps it so clipped sprites show their right part.
    assign w_x0  = $signed({1'b0, i_pos}) - $signed({4'd0, w_g.w}) + 11'sd1;
    assign w_col = $signed({1'b0, i_h}) - w_x0;
    assign w_row = $signed({1'b0, i_v}) - ($signed({2'd0, w_g.b}) - $signed({5'd0, w_g.h}) + 11'sd1);
    assign w_hit = i_en && w_g.ok && w_col >= 0 && i_h <= i_pos && w_row >= 0 && i_v <= {1'b0, w_g.b};
    assign w_addr = ADDR_W'(16'(w_row) * 16'(w_g.w) + 16'(w_col)
                    + ((i_phase && w_g.id == ID_BIRD) ? 16'(BIRD_FRAME_WORDS) : 16'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            o_hit  <= 1'b0;
            o_addr <= '0;
            o_id   <= '0;
        end else begin
            o_hit <= w_hit;
            o_id  <= w_g.id;
            if (w_hit) o_addr <= w_addr;
        end
    end
endmodule

// File: rtl/danger_sprite_engine.sv
// danger_sprite_engine: per-frame latched obstacle sprites composited over white, with overlap flag.
// Define DANGER_ANIM_EN to enable the two-frame bird wing animation.
module danger_sprite_engine
    import danger_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int ROM_LAT     = 1,
    parameter int ADDR_W      = 12,
    parameter int LATCH_LINE  = 308,
    parameter int ANIM_PERIOD = 12
) (
    input logic clk,
    input logic rst,
    danger_sprite_engine_if.slave bus
);
    logic [NUM_CH*10-1:0] r_pos;
    logic [NUM_CH*3-1:0]  r_type;
    logic [NUM_CH-1:0]    r_en;
    logic [NUM_CH-1:0]    r_hd [ROM_LAT];
    logic [NUM_CH-1:0]    w_hit;
    logic                 w_latch;
    logic                 w_phase;
    logic [11:0]          w_rgb;
    logic [3:0]           w_cnt;

    assign w_latch = bus.v_cnt == 10'(LATCH_LINE) && bus.h_cnt == 10'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= '0;
            r_type <= '0;
            r_en   <= '0;
        end else if (w_latch) begin
            r_pos  <= bus.danger_pos;
            r_type <= bus.danger_type;
            r_en   <= bus.danger_en;
        end
    end

`ifdef DANGER_ANIM_EN
    logic [7:0] r_frame;
    logic       r_phase;

    // Dropping anim_run clears even on a latch cycle.
    always_ff @(posedge clk) begin
        if (rst || !bus.anim_run) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_latch) begin
            r_frame <= (r_frame == 8'(ANIM_PERIOD - 1)) ? 8'd0 : r_frame + 8'd1;
            r_phase <= r_phase ^ (r_frame == 8'(ANIM_PERIOD - 1));
        end
    end

    assign w_phase = r_phase;
`else
    logic w_unused;
    assign w_unused = bus.anim_run | (ANIM_PERIOD != 0);
    assign w_phase  = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        danger_ch_addr #(.ADDR_W(ADDR_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_en    (r_en[i]),
            .i_type  (r_type[i*3 +: 3]),
            .i_pos   (r_pos[i*10 +: 10]),
            .i_h     (bus.h_cnt),
            .i_v     (bus.v_cnt),
            .i_phase (w_phase),
            .o_hit   (w_hit[i]),
            .o_addr  (bus.rom_addr[i*ADDR_W +: ADDR_W]),
            .o_id    (bus.rom_id[i*2 +: 2])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ROM_LAT; k++) r_hd[k] <= '0;
        end else begin
            r_hd[0] <= w_hit;
            for (int k = 1; k < ROM_LAT; k++) r_hd[k] <= r_hd[k-1];
        end
    end

    always_comb begin
        w_rgb = 12'hFFF;
        w_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_rgb = w_rgb & (r_hd[ROM_LAT-1][i] ? bus.rom_data[i*12 +: 12] : 12'hFFF);
            w_cnt = w_cnt + 4'(r_hd[ROM_LAT-1][i] && bus.rom_data[i*12 +: 12] != 12'hFFF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rgb     <= 12'hFFF;
            bus.overlap <= 1'b0;
        end else begin
            bus.rgb     <= w_rgb;
            bus.overlap <= w_cnt >= 4'd2;
        end
    end
endmodule

// File: doc/danger_sprite_engine.md
# danger_sprite_engine

Parametrised obstacle renderer for the dino game's VGA path: draws up to `NUM_CH` obstacle sprites (cacti, low/high birds) over a white background and outputs one composited 12-bit pixel per clock. It replaces the fixed three-channel obstacle generator:
- obstacle state is latched once per frame so mid-frame updates cannot tear;
- sprite ROMs sit outside the block behind a fixed-latency address/data interface;
- it reports per-pixel obstacle overlap.

It sits between the obstacle scheduler and the final VGA colour mixer.

## Interface
Parameters:
- `NUM_CH`, 3: number of obstacle channels (1..8).
- `ROM_LAT`, 1: sprite ROM read latency in cycles (1..3).
- `ADDR_W`, 12: sprite ROM address width.
- `LATCH_LINE`, 308: `v_cnt` value on which obstacle state is captured.
- `ANIM_PERIOD`, 12: frames per bird wing phase.

Ports:
- `clk` in 1: pixel-pipeline clock, the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `danger_pos` in `NUM_CH*10`: right-edge x of each obstacle, packed, channel 0 in the LSBs.
- `danger_type` in `NUM_CH*3`: type code per channel (`danger_pkg`).
- `danger_en` in `NUM_CH`: channel enable.
- `anim_run` in 1: game is in the start/running state; enables bird animation.
- `h_cnt`, `v_cnt` in 10 each: current raster coordinate.
- `rom_addr` out `NUM_CH*ADDR_W`: per-channel sprite ROM address.
- `rom_id` out `NUM_CH*2`: per-channel sprite select: 0 small cactus, 1 big cactus, 2 many cactus, 3 bird.
- `rom_data` in `NUM_CH*12`: per-channel ROM pixel, valid `ROM_LAT` cycles after `rom_addr`.
- `rgb` out 12: composited pixel `{R,G,B}`.
- `overlap` out 1: two or more channels are opaque at this pixel.

## Operation
- **Frame latch.** On the cycle with `v_cnt==LATCH_LINE && h_cnt==0`, capture `danger_pos`, `danger_type` and `danger_en` into shadow registers for all channels. Rendering uses only the shadow copies.
- **Geometry per type.** Each type has a width W, a height H and a base line B, all from `danger_pkg`:
  - SMALL: 19×36, B=298.
  - BIG: 27×50, B=298.
  - MANY: 77×49, B=298.
  - LOW_BIRD: 47×42, B=290.
  - HIGH_BIRD: 47×42, B=250.
  - NOTHING, codes 6..7, or a disabled channel: never hit.
- **Hit test.** A channel hits when `max(0, pos-W+1) <= h_cnt <= pos` and `B-H+1 <= v_cnt <= B`. Do the arithmetic in 11-bit signed so a `pos < W-1` start clamps to 0 without wrap.
- **Address.** Address = `row*W + col`, with `row = v_cnt-(B-H+1)` and `col = h_cnt-(pos-W+1)`. `col` uses the unclamped start, so a sprite partially off the left edge shows its right-hand part. Bird address adds `phase*47*42`.
- **Address on a miss.** `rom_addr` holds its last value on a non-hit cycle; `rom_id` always follows the shadow type.
- **Compositing.** Non-hitting channels contribute 12'hFFF. `rgb` is the bitwise AND of all channel contributions.
- **Overlap.** A channel is opaque when it hits and its `rom_data != 12'hFFF`. `overlap` = popcount(opaque) ≥ 2.
- **Animation.**
  - The frame counter advances on each latch event while `anim_run=1`.
  - On reaching `ANIM_PERIOD-1` the counter wraps to 0 and `phase` toggles.
  - `anim_run=0` clears both the counter and `phase` to 0 on the next cycle.
- **Simultaneous events.** If a latch event and `anim_run` falling occur in the same cycle, the clear wins.

## Timing
- **Pipeline stages.**
  - Stage 0 (registered): hit flags and `rom_addr`/`rom_id`, one cycle after `h_cnt`/`v_cnt`.
  - Hit flags are delayed `ROM_LAT` cycles to align with `rom_data`.
  - `rgb`/`overlap` are registered one cycle after data alignment.
- **Total latency.** `h_cnt`/`v_cnt` → `rgb` is `ROM_LAT+2` cycles, constant, with no stalls. The colour mixer compensates for this latency.
- **Latch visibility.** Shadow registers update on the cycle after the latch event; the new state applies to pixels sampled from the next cycle onward.
- **Reset values.**
  - `rgb=12'hFFF`, `overlap=0`, `rom_addr=0`, `rom_id=0`.
  - Shadow `danger_en=0`, `phase=0`, frame counter 0.
  - Pipeline hit flags 0.
- **Reset mid-frame.** Output stays white until the next latch event.

## Configuration
- `DANGER_ANIM_EN` defined: frame counter and `phase` are implemented; the bird address toggles between the two frames every `ANIM_PERIOD` frames while `anim_run=1`.
- `DANGER_ANIM_EN` undefined: no counter; `phase` is a constant 0; `anim_run` is ignored; the bird ROM holds a single frame.

## Structure
- `danger_pkg` holds:
  - type codes LOW_BIRD=0, HIGH_BIRD=1, SMALL=2, MANY=3, BIG=4, NOTHING=5;
  - width/height/base constants and ROM id codes;
  - `BIRD_FRAME_WORDS=1974`.
- Sub-module `danger_ch_addr`, one instance per channel via generate. It performs the hit test and the address calculation for one shadow channel and returns a registered hit plus `rom_addr`/`rom_id`.
- The top level holds the frame latch, the animation counter, the hit delay line, compositing and overlap.

## Test plan
- **Reset.** `rst=1` for 3 cycles, then raster sweep with all enables 0 → `rgb==12'hFFF` everywhere, `overlap==0`.
- **Single cactus.** Ch0 SMALL at pos=100, latch → hit exactly for x 82..100, y 263..298. Pixel (82,263) requests addr 0; (100,298) requests addr 683. `rgb` appears `ROM_LAT+2` cycles later.
- **Left clamp.** Ch1 MANY at pos=10 → hit for x 0..10. At (0,250) the address is `0*77+66=66`; no hit at x=1023.
- **Overlap.** Ch0 BIG at pos=200 and Ch2 SMALL at pos=195, both ROMs returning 12'h000 → `overlap=1` on shared opaque pixels and `rgb=12'h000`.
- **Tear-free update.** Change `danger_pos` at `v_cnt=100` → rendered x stays at the old value until the latch line, then moves.
- **Animation (`DANGER_ANIM_EN`, `ANIM_PERIOD=2`).** `anim_run=1`, LOW_BIRD → bird base address alternates 0/1974 every 2 frames. Dropping `anim_run` → 0 from the next frame.
